// File: rtl/cam_hit_scanner_pkg.sv
// Shared types for the CAM hit scanner: scan FSM states and direction codes.
package cam_hit_scanner_pkg;

  // state | meaning
  // IDLE  | waiting for a hit vector, in_ready high
  // SCAN  | presenting one hit index per cycle until the mask drains or the limit is reached
  // DONE  | one-cycle done pulse carrying the final hit count
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/cam_scan_prienc.sv
// Direction-selectable priority encoder over the remaining hit mask.
// idx is the lowest set bit for DIR_ASC and the highest for DIR_DESC;
// last flags that exactly one bit is set.
module cam_scan_prienc
  import cam_hit_scanner_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  input  logic             dir,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             last
);

  // Later matches overwrite earlier ones, so loop order picks the winning end.
  always_comb begin
    idx = '0;
    if (dir == DIR_ASC) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (mask[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (mask[i]) idx = IDX_W'(i);
      end
    end
  end

  assign any  = |mask;
  assign last = any && ((mask & (mask - WIDTH'(1))) == '0);

endmodule

// File: rtl/cam_hit_scanner.sv
// Walks a CAM hit vector and streams the index of each set bit, one per
// cycle, then pulses done with the number of hits emitted.
// Optional feature: define CAM_HIT_SCANNER_LIMIT_EN to add a max_hits limit
// (sampled at accept, 0 = unlimited) and a truncated flag valid with done.
module cam_hit_scanner
  import cam_hit_scanner_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_dir,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [IDX_W-1:0] hit_idx,
  output logic             done_valid,
  output logic [CNT_W-1:0] done_count,
`ifdef CAM_HIT_SCANNER_LIMIT_EN
  input  logic [CNT_W-1:0] max_hits,
  output logic             truncated,
`endif
  output logic             busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   done_count_q, done_count_d;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
  logic [CNT_W-1:0]   max_q, max_d;
  logic               trunc_q, trunc_d;
`endif

  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;
  logic               enc_last;
  logic [WIDTH-1:0]   mask_cleared;
  logic [CNT_W-1:0]   count_inc;
  logic               limit_hit;

  cam_scan_prienc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_prienc (
    .mask (mask_q),
    .dir  (dir_q),
    .idx  (enc_idx),
    .any  (enc_any),
    .last (enc_last)
  );

  // Everything downstream sees is decoded from registers only.
  assign in_ready   = (state_q == IDLE);
  assign hit_valid  = (state_q == SCAN);
  assign done_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign hit_idx    = enc_idx;
  assign done_count = done_count_q;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
  assign truncated  = trunc_q;
`endif

  assign mask_cleared = mask_q & ~(WIDTH'(1) << enc_idx);
  assign count_inc    = count_q + CNT_W'(1);
`ifdef CAM_HIT_SCANNER_LIMIT_EN
  assign limit_hit    = (max_q != '0) && (count_inc == max_q);
`else
  assign limit_hit    = 1'b0;
`endif

  // Next-state logic: accept in IDLE, retire one hit per handshake in SCAN.
  // done_count is loaded on the way into DONE so it is valid with the pulse.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    dir_d        = dir_q;
    count_d      = count_q;
    done_count_d = done_count_q;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
    max_d        = max_q;
    trunc_d      = trunc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mask_d       = in_vec;
          dir_d        = in_dir;
          count_d      = '0;
          done_count_d = '0;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
          max_d        = max_hits;
          trunc_d      = 1'b0;
`endif
          state_d      = (in_vec == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (hit_ready && enc_any) begin
          mask_d  = mask_cleared;
          count_d = count_inc;
          if (enc_last || limit_hit) begin
            state_d      = DONE;
            done_count_d = count_inc;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
            trunc_d      = |mask_cleared;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      dir_q        <= DIR_ASC;
      count_q      <= '0;
      done_count_q <= '0;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
      max_q        <= '0;
      trunc_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      dir_q        <= dir_d;
      count_q      <= count_d;
      done_count_q <= done_count_d;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
      max_q        <= max_d;
      trunc_q      <= trunc_d;
`endif
    end
  end

endmodule

// File: tb/tb_cam_hit_scanner.sv
// Self-checking bench for cam_hit_scanner: a queue-based model of the
// expected hit stream is compared against the DUT every cycle, with a few
// directed scans pinned to hand-computed hit lists and counts.
module tb_cam_hit_scanner;

  localparam int WIDTH = 64;
  localparam int IDX_W = 6;
  localparam int CNT_W = 7;

  localparam logic [63:0] V_SPARSE = 64'h00010000_00010000;
  localparam logic [63:0] V_MULTI  = 64'h01010010_00010001;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             in_dir;
  logic             hit_valid;
  logic             hit_ready;
  logic [IDX_W-1:0] hit_idx;
  logic             done_valid;
  logic [CNT_W-1:0] done_count;
  logic             busy;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
  logic [CNT_W-1:0] max_hits;
  logic             truncated;
`endif

  cam_hit_scanner #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .in_dir     (in_dir),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_idx    (hit_idx),
    .done_valid (done_valid),
    .done_count (done_count),
`ifdef CAM_HIT_SCANNER_LIMIT_EN
    .max_hits   (max_hits),
    .truncated  (truncated),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the pending hit indices as a queue, plus idle/done flags.
  bit  check_en = 0;
  bit  m_idle = 1;
  bit  m_done = 0;
  bit  m_trunc = 0;
  int  m_q[$];
  int  m_cnt = 0;
  int  m_done_count = 0;
  int  act_log[$];
  int  exp_log[$];

  always @(posedge clk) begin
    if (hit_valid && hit_ready && !reset) act_log.push_back(int'(hit_idx));
    if (reset) begin
      check_en     = 1;
      m_idle       = 1;
      m_done       = 0;
      m_trunc      = 0;
      m_q.delete();
      m_cnt        = 0;
      m_done_count = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_q.delete();
        if (in_dir == 1'b0) begin
          for (int i = 0; i < WIDTH; i++) if (in_vec[i]) m_q.push_back(i);
        end else begin
          for (int i = WIDTH - 1; i >= 0; i--) if (in_vec[i]) m_q.push_back(i);
        end
        m_trunc = 0;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
        if (max_hits != 0 && m_q.size() > int'(max_hits)) begin
          m_trunc = 1;
          while (m_q.size() > int'(max_hits)) void'(m_q.pop_back());
        end
`endif
        m_cnt        = 0;
        m_done_count = 0;
        m_idle       = 0;
        m_done       = (m_q.size() == 0);
      end
    end else if (m_done) begin
      m_done = 0;
      m_idle = 1;
    end else if (hit_ready) begin
      void'(m_q.pop_front());
      m_cnt++;
      if (m_q.size() == 0) begin
        m_done       = 1;
        m_done_count = m_cnt;
      end
    end
  end

  // Compare process: every output against the model, on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", in_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("hit_valid", hit_valid, !m_idle && !m_done);
      chk("done_valid", done_valid, m_done);
      chk("done_count", done_count, m_done_count);
      if (!m_idle && !m_done && m_q.size() > 0) chk("hit_idx", hit_idx, m_q[0]);
`ifdef CAM_HIT_SCANNER_LIMIT_EN
      if (m_done) chk("truncated", truncated, m_trunc);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, act_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < act_log.size(); i++)
      chk(nm, act_log[i], exp_log[i]);
  endtask

  // Offer one vector and drain it; returns cycles from accept to done and the
  // done_count seen during the done pulse.
  task automatic run_vec(input logic [63:0] v, input logic d, input bit rnd,
                         output int lat, output int dc);
    act_log.delete();
    in_valid  = 1'b1;
    in_vec    = v;
    in_dir    = d;
    hit_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 400) begin
      if (rnd) begin
        hit_ready = ($urandom_range(0, 3) != 0);
        in_valid  = $urandom_range(0, 1);
        in_vec    = {$urandom, $urandom};
        in_dir    = $urandom_range(0, 1);
      end else begin
        hit_ready = 1'b1;
      end
      step();
      lat++;
    end
    if (!done_valid) chk("scan_timeout", lat, -1);
    dc = int'(done_count);
    in_valid  = 1'b0;
    hit_ready = 1'b1;
    step();
  endtask

  int lat, dc;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    in_dir    = 1'b0;
    hit_ready = 1'b0;
`ifdef CAM_HIT_SCANNER_LIMIT_EN
    max_hits  = '0;
`endif
    step();
    step();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_count", done_count, 0);
    step();

    // Sparse vector, both directions.
    run_vec(V_SPARSE, 1'b0, 1'b0, lat, dc);
    exp_log = '{16, 48};
    check_log("sparse_asc");
    chk("sparse_asc_lat", lat, 3);
    chk("sparse_asc_cnt", dc, 2);
    run_vec(V_SPARSE, 1'b1, 1'b0, lat, dc);
    exp_log = '{48, 16};
    check_log("sparse_desc");
    chk("sparse_desc_cnt", dc, 2);

    // Multi-hit vector, both directions.
    run_vec(V_MULTI, 1'b0, 1'b0, lat, dc);
    exp_log = '{0, 16, 36, 48, 56};
    check_log("multi_asc");
    chk("multi_asc_lat", lat, 6);
    chk("multi_asc_cnt", dc, 5);
    run_vec(V_MULTI, 1'b1, 1'b0, lat, dc);
    exp_log = '{56, 48, 36, 16, 0};
    check_log("multi_desc");
    chk("multi_desc_cnt", dc, 5);

    // Empty and full vectors.
    run_vec(64'h0, 1'b0, 1'b0, lat, dc);
    exp_log.delete();
    check_log("empty");
    chk("empty_lat", lat, 1);
    chk("empty_cnt", dc, 0);
    run_vec({64{1'b1}}, 1'b0, 1'b0, lat, dc);
    exp_log.delete();
    for (int i = 0; i < 64; i++) exp_log.push_back(i);
    check_log("full");
    chk("full_cnt", dc, 64);

    // Backpressure on the second hit with a competing vector offered.
    act_log.delete();
    in_valid = 1'b1; in_vec = V_MULTI; in_dir = 1'b0; hit_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    hit_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = {64{1'b1}};
    in_dir    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hit_idx", hit_idx, 16);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    hit_ready = 1'b1;
    lat = 0;
    while (!done_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("bp_cnt", done_count, 5);
    step();
    exp_log = '{0, 16, 36, 48, 56};
    check_log("bp");

    // Reset in the middle of a scan.
    act_log.delete();
    in_valid = 1'b1; in_vec = V_MULTI; in_dir = 1'b0; hit_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_hit_valid", hit_valid, 0);
    chk("mid_rst_done_valid", done_valid, 0);
    chk("mid_rst_done_count", done_count, 0);
    for (int i = 0; i < 3; i++) step();
    exp_log = '{0, 16};
    check_log("mid_rst");

`ifdef CAM_HIT_SCANNER_LIMIT_EN
    max_hits = 7'd4;
    act_log.delete();
    in_valid = 1'b1; in_vec = V_MULTI; in_dir = 1'b0; hit_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 100) begin
      step();
      lat++;
    end
    chk("limit_cnt", done_count, 4);
    chk("limit_trunc", truncated, 1);
    step();
    exp_log = '{0, 16, 36, 48};
    check_log("limit");
    max_hits = '0;
`endif

    // Randomized scans against the model.
    for (int n = 0; n < 60; n++) begin
      logic [63:0] v;
      case ($urandom_range(0, 3))
        0: v = {$urandom, $urandom};
        1: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2: begin v = '0; v[$urandom_range(0, 63)] = 1'b1; end
        default: v = ($urandom_range(0, 1) != 0) ? {64{1'b1}} : 64'h0;
      endcase
`ifdef CAM_HIT_SCANNER_LIMIT_EN
      max_hits = CNT_W'($urandom_range(0, 8));
`endif
      run_vec(v, $urandom_range(0, 1), 1'b1, lat, dc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
